unidade_controle: RTL and testbench
===================================

# unidade_controle

Control unit of the ultimate tic-tac-toe board. A Moore FSM that sequences the board datapath through start-up, macro-cell choice, micro-cell play, board write-back, game-end check and player swap. It consumes the datapath status flags (`tem_jogada`, `macro_vencida`, `micro_jogada`, `fim_jogo`, `fimT`) and drives every register, memory and timer control.

## Interface
- Parameters: none.
- `clock` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `iniciar` in 1: level; starts a game from `inicial` or `fim`.
- `tem_jogada` in 1: one-cycle button-press pulse from the datapath.
- `macro_vencida` in 1: the selected macro cell is already decided.
- `micro_jogada` in 1: the selected micro cell is occupied.
- `fim_jogo` in 1: the whole board is decided.
- `fimT` in 1: the move timer has expired.
- Register/edge control outputs, 1 bit each: `zeraEdge`, `zeraR_micro`, `zeraR_macro`, `zeraFlipFlopT`, `registraR_micro`, `registraR_macro`.
- Mux select outputs, 1 bit each: `sinal_macro` (1 = macro register loads from buttons, 0 = loads from micro), `sinal_valida_macro` (1 = validate macro, 0 = validate micro).
- Write/turn outputs, 1 bit each: `we_board`, `we_board_state`, `troca_jogador`.
- Timer outputs, 1 bit each: `contaT`, `zeraT`.
- `pronto` out 1: high in `fim`.
- `db_estado` out 4: current state encoding.

## Operation
- There are 16 states, encoded 4'h0–4'hF in the listed order. Outputs are Moore; any output not listed for a state is 0.
- `inicial`: idle. Goes to `preparacao` when `iniciar`=1.
- `preparacao`: asserts `zeraEdge`, `zeraR_micro`, `zeraR_macro`, `zeraFlipFlopT`, `zeraT`. Goes to `espera_macro`.
- `espera_macro`: asserts `sinal_macro`, `sinal_valida_macro`, `contaT`.
  - `tem_jogada` goes to `registra_macro`.
  - Otherwise `fimT` goes to `timeout`.
- `registra_macro`: asserts `registraR_macro`, `sinal_macro`, `zeraT`. Goes to `valida_macro`.
- `valida_macro`: asserts `sinal_valida_macro`. `macro_vencida`=1 goes to `espera_macro`; 0 goes to `espera_micro`.
- `espera_micro`: asserts `contaT`. `tem_jogada` goes to `registra_micro`, else `fimT` goes to `timeout`.
- `registra_micro`: asserts `registraR_micro`, `zeraT`. Goes to `valida_micro`.
- `valida_micro`: `micro_jogada`=1 goes to `espera_micro`; 0 goes to `escreve_jogada`.
- `escreve_jogada`: asserts `we_board`. Goes to `atualiza_macro`.
- `atualiza_macro`: asserts `we_board_state`. Goes to `verifica_fim`.
- `verifica_fim`: `fim_jogo`=1 goes to `fim`; 0 goes to `troca`.
- `troca`: asserts `troca_jogador`. Goes to `proxima_macro`.
- `proxima_macro`: asserts `registraR_macro` with `sinal_macro`=0, so next macro = last micro. Goes to `valida_proxima`.
- `valida_proxima`: asserts `sinal_valida_macro`, `zeraT`.
  - `macro_vencida`=1 goes to `espera_macro` (free choice).
  - 0 goes to `espera_micro` (forced cell).
- `timeout`: asserts `troca_jogador`, `zeraT`, `zeraR_micro`. Goes to `espera_macro`; the next player chooses freely.
- `fim`: asserts `pronto`. Goes to `preparacao` when `iniciar`=1.
- `tem_jogada` and `fimT` asserted in the same wait cycle: `tem_jogada` wins.
- `tem_jogada` arriving in any non-wait state is ignored; it is not latched.

## Timing
- Reset: `reset_n`=0 sampled at an edge forces `inicial`. All outputs are 0 and `db_estado`=4'h0 from that edge on. This holds mid-game as well, including during a write state.
- Flag contract: the datapath presents `macro_vencida`/`micro_jogada` valid in the cycle after the corresponding `registra*` state. `fim_jogo` is valid in the cycle after `we_board_state`.
- Minimum cycles from a valid micro press (`tem_jogada` edge in `espera_micro`) to the `troca` state: 6.
- Every write enable (`we_board`, `we_board_state`) is high for exactly one cycle per accepted move.
- `troca_jogador` is high for exactly one cycle per turn change.

## Configuration
- `UNIDADE_CONTROLE_TIMEOUT_EN` defined: timer behaviour exactly as above.
- Undefined:
  - `contaT` is tied to 0.
  - `fimT` is ignored; `timeout` is unreachable. If entered, it falls through to `inicial`.
  - `zeraT` is still asserted where listed.

## Structure
- Shared package `jogo_pkg` holds the 4-bit state typedef and the 16 named state constants. The datapath's debug display also uses them.
- No sub-module: a single two-process FSM (state register plus next-state/output logic).

## Test plan
- Reset check: `reset_n`=0 for 2 cycles, then 1 → `db_estado`=0, all outputs 0; with `iniciar`=1 the FSM reaches `espera_macro` after 2 cycles.
- Valid move: macro press with `macro_vencida`=0, then micro press with `micro_jogada`=0 → one `we_board` pulse, one `we_board_state` pulse, one `troca_jogador` pulse, FSM in `espera_micro` when the forced macro is free.
- Occupied micro: `micro_jogada`=1 at validation → FSM returns to `espera_micro`, no write enables asserted.
- Decided macro: `macro_vencida`=1 in `valida_proxima` → FSM goes to `espera_macro`.
- Game end: `fim_jogo`=1 in `verifica_fim` → `pronto`=1 and `db_estado`=4'hF; `iniciar` then → `preparacao` with all `zera*` asserted.
- Timeout (macro defined): `fimT`=1 in `espera_micro` → `troca_jogador` for 1 cycle, then `espera_macro`. With the macro undefined, the FSM stays in `espera_micro` and `contaT`=0.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared state encoding for the ultimate tic-tac-toe control unit and the
// datapath debug display.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA_MACRO   = 4'h2,
        REGISTRA_MACRO = 4'h3,
        VALIDA_MACRO   = 4'h4,
        ESPERA_MICRO   = 4'h5,
        REGISTRA_MICRO = 4'h6,
        VALIDA_MICRO   = 4'h7,
        ESCREVE_JOGADA = 4'h8,
        ATUALIZA_MACRO = 4'h9,
        VERIFICA_FIM   = 4'hA,
        TROCA          = 4'hB,
        PROXIMA_MACRO  = 4'hC,
        VALIDA_PROXIMA = 4'hD,
        TIMEOUT        = 4'hE,
        FIM            = 4'hF
    } estado_t;

endpackage

// File: rtl/unidade_controle.sv
// Moore control FSM for the ultimate tic-tac-toe board datapath.
// Define UNIDADE_CONTROLE_TIMEOUT_EN to enable the move timer and timeout path.
module unidade_controle
    import jogo_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       macro_vencida,
    input  logic       micro_jogada,
    input  logic       fim_jogo,
    input  logic       fimT,
    output logic       zeraEdge,
    output logic       zeraR_micro,
    output logic       zeraR_macro,
    output logic       zeraFlipFlopT,
    output logic       registraR_micro,
    output logic       registraR_macro,
    output logic       sinal_macro,
    output logic       sinal_valida_macro,
    output logic       we_board,
    output logic       we_board_state,
    output logic       troca_jogador,
    output logic       contaT,
    output logic       zeraT,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t estado_q, estado_d;
    logic    expirou;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    assign expirou = fimT;
`else
    logic unused_fimt;
    assign unused_fimt = fimT;
    assign expirou     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) estado_q <= INICIAL;
        else          estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL:        if (iniciar) estado_d = PREPARACAO;
            PREPARACAO:     estado_d = ESPERA_MACRO;
            // a press beats a simultaneous timer expiry
            ESPERA_MACRO:   if (tem_jogada) estado_d = REGISTRA_MACRO;
                            else if (expirou) estado_d = TIMEOUT;
            REGISTRA_MACRO: estado_d = VALIDA_MACRO;
            VALIDA_MACRO:   estado_d = macro_vencida ? ESPERA_MACRO : ESPERA_MICRO;
            ESPERA_MICRO:   if (tem_jogada) estado_d = REGISTRA_MICRO;
                            else if (expirou) estado_d = TIMEOUT;
            REGISTRA_MICRO: estado_d = VALIDA_MICRO;
            VALIDA_MICRO:   estado_d = micro_jogada ? ESPERA_MICRO : ESCREVE_JOGADA;
            ESCREVE_JOGADA: estado_d = ATUALIZA_MACRO;
            ATUALIZA_MACRO: estado_d = VERIFICA_FIM;
            VERIFICA_FIM:   estado_d = fim_jogo ? FIM : TROCA;
            TROCA:          estado_d = PROXIMA_MACRO;
            PROXIMA_MACRO:  estado_d = VALIDA_PROXIMA;
            VALIDA_PROXIMA: estado_d = macro_vencida ? ESPERA_MACRO : ESPERA_MICRO;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            TIMEOUT:        estado_d = ESPERA_MACRO;
`else
            TIMEOUT:        estado_d = INICIAL;
`endif
            FIM:            if (iniciar) estado_d = PREPARACAO;
            default:        estado_d = INICIAL;
        endcase
    end

    always_comb begin
        zeraEdge           = 1'b0;
        zeraR_micro        = 1'b0;
        zeraR_macro        = 1'b0;
        zeraFlipFlopT      = 1'b0;
        registraR_micro    = 1'b0;
        registraR_macro    = 1'b0;
        sinal_macro        = 1'b0;
        sinal_valida_macro = 1'b0;
        we_board           = 1'b0;
        we_board_state     = 1'b0;
        troca_jogador      = 1'b0;
        contaT             = 1'b0;
        zeraT              = 1'b0;
        pronto             = 1'b0;
        unique case (estado_q)
            PREPARACAO: begin
                zeraEdge      = 1'b1;
                zeraR_micro   = 1'b1;
                zeraR_macro   = 1'b1;
                zeraFlipFlopT = 1'b1;
                zeraT         = 1'b1;
            end
            ESPERA_MACRO: begin
                sinal_macro        = 1'b1;
                sinal_valida_macro = 1'b1;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                contaT             = 1'b1;
`endif
            end
            REGISTRA_MACRO: begin
                registraR_macro = 1'b1;
                sinal_macro     = 1'b1;
                zeraT           = 1'b1;
            end
            VALIDA_MACRO:   sinal_valida_macro = 1'b1;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            ESPERA_MICRO:   contaT = 1'b1;
`endif
            REGISTRA_MICRO: begin
                registraR_micro = 1'b1;
                zeraT           = 1'b1;
            end
            ESCREVE_JOGADA: we_board       = 1'b1;
            ATUALIZA_MACRO: we_board_state = 1'b1;
            TROCA:          troca_jogador  = 1'b1;
            // sinal_macro stays 0 so the last micro becomes the next macro
            PROXIMA_MACRO:  registraR_macro = 1'b1;
            VALIDA_PROXIMA: begin
                sinal_valida_macro = 1'b1;
                zeraT              = 1'b1;
            end
            TIMEOUT: begin
                troca_jogador = 1'b1;
                zeraT         = 1'b1;
                zeraR_micro   = 1'b1;
            end
            FIM:            pronto = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle; honours
// UNIDADE_CONTROLE_TIMEOUT_EN for the timer-dependent expectations.
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset_n, iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT;
    logic       zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, registraR_micro, registraR_macro;
    logic       sinal_macro, sinal_valida_macro, we_board, we_board_state, troca_jogador;
    logic       contaT, zeraT, pronto;
    logic [3:0] db_estado;

    int n_chk  = 0;
    int n_pass = 0;

    unidade_controle dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .tem_jogada(tem_jogada),
        .macro_vencida(macro_vencida), .micro_jogada(micro_jogada), .fim_jogo(fim_jogo),
        .fimT(fimT), .zeraEdge(zeraEdge), .zeraR_micro(zeraR_micro), .zeraR_macro(zeraR_macro),
        .zeraFlipFlopT(zeraFlipFlopT), .registraR_micro(registraR_micro),
        .registraR_macro(registraR_macro), .sinal_macro(sinal_macro),
        .sinal_valida_macro(sinal_valida_macro), .we_board(we_board),
        .we_board_state(we_board_state), .troca_jogador(troca_jogador), .contaT(contaT),
        .zeraT(zeraT), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Bit order: zeraEdge zR_micro zR_macro zFFT regR_micro regR_macro sinal_macro
    //            sinal_valida we_board we_board_state troca contaT zeraT pronto
    logic [13:0] outs;
    assign outs = {zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, registraR_micro,
                   registraR_macro, sinal_macro, sinal_valida_macro, we_board, we_board_state,
                   troca_jogador, contaT, zeraT, pronto};

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    localparam logic CT = 1'b1;
`else
    localparam logic CT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; iniciar = 1'b0; tem_jogada = 1'b0; macro_vencida = 1'b0;
        micro_jogada = 1'b0; fim_jogo = 1'b0; fimT = 1'b0;
        tick(); tick();
        chk("reset_state", db_estado, 4'h0);
        chk("reset_outs", outs, 14'h0);

        reset_n = 1'b1; iniciar = 1'b1;
        tick();
        chk("prep_state", db_estado, 4'h1);
        chk("prep_outs", outs, 14'b11110000000010);
        tick();
        iniciar = 1'b0;
        chk("esp_macro_state", db_estado, 4'h2);
        chk("esp_macro_outs", outs, {11'b00000011000, CT, 2'b00});
        tick();
        chk("esp_macro_hold", db_estado, 4'h2);

        // press and timer expiry together: press wins
        tem_jogada = 1'b1; fimT = 1'b1;
        tick();
        tem_jogada = 1'b0; fimT = 1'b0;
        chk("reg_macro_state", db_estado, 4'h3);
        chk("reg_macro_outs", outs, 14'b00000110000010);
        tick();
        chk("val_macro_state", db_estado, 4'h4);
        tick();
        chk("esp_micro_state", db_estado, 4'h5);
        chk("esp_micro_contaT", contaT, CT);

`ifndef UNIDADE_CONTROLE_TIMEOUT_EN
        fimT = 1'b1;
        tick();
        fimT = 1'b0;
        chk("fimT_ignored", db_estado, 4'h5);
        chk("fimT_ignored_contaT", contaT, 1'b0);
`endif

        // occupied micro cell
        tem_jogada = 1'b1;
        tick();
        tem_jogada = 1'b0; micro_jogada = 1'b1;
        chk("reg_micro_outs", outs, 14'b00001000000010);
        tick();
        chk("val_micro_state", db_estado, 4'h7);
        chk("val_micro_outs", outs, 14'h0);
        tick();
        micro_jogada = 1'b0;
        chk("occupied_back", db_estado, 4'h5);
        chk("occupied_no_we", {we_board, we_board_state}, 2'b00);

        // valid move: press to troca in 6 cycles
        tem_jogada = 1'b1;
        tick();
        tem_jogada = 1'b0;
        tick();
        tick();
        chk("we_board_pulse", {db_estado, outs}, {4'h8, 14'b00000000100000});
        tick();
        chk("we_state_pulse", {db_estado, outs}, {4'h9, 14'b00000000010000});
        tick();
        chk("verifica_outs", {db_estado, outs}, {4'hA, 14'h0});
        tick();
        chk("troca_6cyc", {db_estado, outs}, {4'hB, 14'b00000000001000});
        tick();
        chk("proxima_outs", {db_estado, outs}, {4'hC, 14'b00000100000000});
        tick();
        chk("valida_prox_outs", {db_estado, outs}, {4'hD, 14'b00000001000010});
        tick();
        chk("forced_micro", db_estado, 4'h5);
        chk("troca_single", troca_jogador, 1'b0);

        // second move, forced macro already decided
        tem_jogada = 1'b1;
        tick();
        tem_jogada = 1'b0;
        repeat (6) tick();
        macro_vencida = 1'b1;
        tick();
        chk("vp_state", db_estado, 4'hD);
        tick();
        macro_vencida = 1'b0;
        chk("free_choice", db_estado, 4'h2);

        // third move ends the game
        tem_jogada = 1'b1;
        tick();
        tem_jogada = 1'b0;
        tick(); tick();
        tem_jogada = 1'b1;
        tick();
        tem_jogada = 1'b0;
        tick(); tick(); tick();
        fim_jogo = 1'b1;
        tick();
        chk("verifica_state", db_estado, 4'hA);
        tick();
        fim_jogo = 1'b0;
        chk("fim_state", db_estado, 4'hF);
        chk("fim_outs", outs, 14'b00000000000001);
        tick();
        chk("fim_hold", db_estado, 4'hF);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("restart_prep", {db_estado, outs}, {4'h1, 14'b11110000000010});
        tick();
        chk("restart_esp", db_estado, 4'h2);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        tem_jogada = 1'b1;
        tick();
        tem_jogada = 1'b0;
        tick(); tick();
        fimT = 1'b1;
        tick();
        fimT = 1'b0;
        chk("timeout_outs", {db_estado, outs}, {4'hE, 14'b01000000001010});
        tick();
        chk("timeout_next", {db_estado, troca_jogador}, {4'h2, 1'b0});
`endif

        // reset in the middle of a write
        tem_jogada = 1'b1;
        tick();
        tem_jogada = 1'b0;
        tick(); tick();
        tem_jogada = 1'b1;
        tick();
        tem_jogada = 1'b0;
        tick(); tick();
        chk("pre_reset_we", {db_estado, we_board}, {4'h8, 1'b1});
        reset_n = 1'b0;
        tick();
        chk("midreset_state", db_estado, 4'h0);
        chk("midreset_outs", outs, 14'h0);
        reset_n = 1'b1;
        tick();
        chk("idle_after_reset", db_estado, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
